// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: FSM states, MIPS opcode/funct
// encodings and the ALU operation set.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_EXEC,
    ST_RWB,
    ST_ADDIEX,
    ST_ADDIWB,
    ST_BRANCH,
    ST_JUMP,
    ST_JR,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Unknown functs fall back to ADD; the FSM never reaches EXEC with one.
  function automatic alu_op_t funct_to_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, synchronous reset, register 0 hardwired to zero.
module mc_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core with req/ready memory handshake and jr support.
// Define MULTICYCLE_CORE_PERF_EN to add cycle_cnt/instret_cnt counters.
module multicycle_core
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_re,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic [XLEN-1:0] pc
`ifdef MULTICYCLE_CORE_PERF_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instret_cnt
`endif
);

  state_t state, next_state;

  logic [31:0]     ir;
  logic [XLEN-1:0] a_reg, b_reg, mdr, alu_out;

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] imm_ext, jump_target;

  logic [XLEN-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [4:0]      rf_waddr;
  logic            rf_we;

  logic [XLEN-1:0] alu_src_a, alu_src_b, alu_result;
  alu_op_t         alu_op;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm_ext     = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign jump_target = {pc[XLEN-1:28], ir[25:0], 2'b00};
  assign mem_wdata   = b_reg;

  mc_regfile #(.XLEN(XLEN)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR)
              next_state = ST_JR;
            else if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
              next_state = ST_EXEC;
            else
              next_state = ST_HALT;
          end
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_ADDI:      next_state = ST_ADDIEX;
          OP_J, OP_JAL: next_state = ST_JUMP;
          default:      next_state = ST_HALT;
        endcase
      end
      ST_MEMADR: next_state = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) next_state = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) next_state = ST_FETCH;
      ST_EXEC:   next_state = ST_RWB;
      ST_ADDIEX: next_state = ST_ADDIWB;
      ST_MEMWB, ST_RWB, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_JR:
                 next_state = ST_FETCH;
      default:   next_state = ST_HALT;
    endcase
  end

  // Requests are state decodes, forced low while reset is asserted so an
  // abandoned access never looks live to the memory.
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = alu_out;
    halted   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (state)
      ST_FETCH: begin
        mem_re   = 1'b1;
        mem_addr = pc;
      end
      ST_MEMRD: mem_re = 1'b1;
      ST_MEMWR: mem_we = 1'b1;
      ST_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr;
      end
      ST_RWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
      end
      ST_ADDIWB: rf_we = 1'b1;
      ST_JUMP: begin
        if (opcode == OP_JAL) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_re = 1'b0;
      mem_we = 1'b0;
    end
  end

  // One shared ALU: branch target in DECODE, register op in EXEC, and
  // base+immediate for address and addi computation.
  always_comb begin
    alu_src_a = a_reg;
    alu_src_b = imm_ext;
    alu_op    = ALU_ADD;
    case (state)
      ST_DECODE: begin
        alu_src_a = pc;
        alu_src_b = imm_ext << 2;
      end
      ST_EXEC: begin
        alu_src_b = b_reg;
        alu_op    = funct_to_alu_op(funct);
      end
      default: ;
    endcase
    case (alu_op)
      ALU_SUB: alu_result = alu_src_a - alu_src_b;
      ALU_AND: alu_result = alu_src_a & alu_src_b;
      ALU_OR:  alu_result = alu_src_a | alu_src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}},
                             ($signed(alu_src_a) < $signed(alu_src_b))};
      default: alu_result = alu_src_a + alu_src_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      mdr     <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata[31:0];
            pc <= pc + XLEN'(4);
          end
        end
        ST_DECODE: begin
          a_reg   <= rf_rdata1;
          b_reg   <= rf_rdata2;
          alu_out <= alu_result;
        end
        ST_MEMADR, ST_EXEC, ST_ADDIEX: alu_out <= alu_result;
        ST_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        ST_BRANCH: if (a_reg == b_reg) pc <= alu_out;
        ST_JUMP:   pc <= jump_target;
        ST_JR:     pc <= a_reg;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CORE_PERF_EN
  // An instruction retires when any non-fetch state hands control back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if ((state != ST_FETCH) && (next_state == ST_FETCH))
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: ISA-level reference model with a per-cycle bus
// schedule, a wait-state memory responder and directed programs.
module tb_multicycle_core;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [31:0] mem_rdata = '0;
  logic        mem_re, mem_we, halted;
  logic        mem_ready = 1'b0;
`ifdef MULTICYCLE_CORE_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc        (pc)
`ifdef MULTICYCLE_CORE_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  logic [31:0] mem [256];
  logic [31:0] mem_model [256];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          we_cycles = 0;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  // Memory responder: completes each access after wait_cfg wait cycles.
  always @(negedge clk) begin
    mem_ready = !rst && (mem_re || mem_we) && (wait_cnt == wait_cfg);
    mem_rdata = mem[mem_addr[9:2]];
    if (mem_we && !rst) we_cycles++;
  end

  always @(posedge clk) begin
    if (rst || !(mem_re || mem_we) || mem_ready) wait_cnt = 0;
    else wait_cnt++;
    if (!rst && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
  end

  typedef struct packed {
    logic        re;
    logic        we;
    logic        first;
    logic [31:0] addr;
    logic [31:0] wdata;
  } slot_t;

  slot_t       sched[$];
  slot_t       cur;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  bit          m_halted, m_halt_pending, chk_en;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  logic [31:0] start_pc_log[$];
  int          start_cyc_log[$];
  int          instr_lat[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushSlots(input int n, input logic re, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit first_flag);
    for (int i = 0; i < n; i++) begin
      slot_t s;
      s.re = re; s.we = we; s.first = first_flag && (i == 0);
      s.addr = addr; s.wdata = wdata;
      sched.push_back(s);
    end
  endtask

  // Executes one instruction architecturally and queues the bus activity
  // expected for each of its cycles.
  task automatic modelStep();
    logic [31:0] ins, rsv, rtv, imm, ea, res;
    logic [4:0]  dst;
    bit          wr;
    ins = mem_model[m_pc[9:2]];
    pushSlots(wait_cfg + 1, 1'b1, 1'b0, m_pc, 32'h0, 1'b1);
    rsv = m_regs[ins[25:21]];
    rtv = m_regs[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    m_pc = m_pc + 32'd4;
    wr = 1'b0; dst = 5'd0; res = 32'h0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
            case (ins[5:0])
              6'h20:   res = rsv + rtv;
              6'h22:   res = rsv - rtv;
              6'h24:   res = rsv & rtv;
              6'h25:   res = rsv | rtv;
              default: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
            endcase
            wr = 1'b1; dst = ins[15:11];
            pushSlots(3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
          end
          6'h08: begin
            m_pc = rsv;
            pushSlots(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
          end
          default: begin
            pushSlots(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            m_halt_pending = 1'b1;
          end
        endcase
      end
      6'h23: begin
        ea = rsv + imm;
        pushSlots(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pushSlots(wait_cfg + 1, 1'b1, 1'b0, ea, 32'h0, 1'b0);
        pushSlots(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        res = mem_model[ea[9:2]]; wr = 1'b1; dst = ins[20:16];
      end
      6'h2B: begin
        ea = rsv + imm;
        pushSlots(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        pushSlots(wait_cfg + 1, 1'b0, 1'b1, ea, rtv, 1'b0);
        mem_model[ea[9:2]] = rtv;
      end
      6'h04: begin
        pushSlots(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        if (rsv == rtv) m_pc = m_pc + (imm << 2);
      end
      6'h08: begin
        res = rsv + imm; wr = 1'b1; dst = ins[20:16];
        pushSlots(3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      end
      6'h02, 6'h03: begin
        pushSlots(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        if (ins[26]) begin res = m_pc; wr = 1'b1; dst = 5'd31; end
        m_pc = {m_pc[31:28], ins[25:0], 2'b00};
      end
      default: begin
        pushSlots(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        m_halt_pending = 1'b1;
      end
    endcase
    if (wr && dst != 5'd0) m_regs[dst] = res;
    instr_lat.push_back(sched.size());
  endtask

  // Compare process: every non-reset cycle against the model's schedule.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (sched.size() == 0 && m_halt_pending) m_halted = 1'b1;
      if (sched.size() == 0 && !m_halted) modelStep();
      if (m_halted) begin
        checkOutput("halted_sticky", halted, 1'b1);
        checkOutput("halt_re", mem_re, 1'b0);
        checkOutput("halt_we", mem_we, 1'b0);
      end else begin
        cur = sched.pop_front();
        checkOutput("halted_low", halted, 1'b0);
        checkOutput("mem_re", mem_re, cur.re);
        checkOutput("mem_we", mem_we, cur.we);
        if (cur.re || cur.we) checkOutput("mem_addr", mem_addr, cur.addr);
        if (cur.we) checkOutput("mem_wdata", mem_wdata, cur.wdata);
        if (cur.first) begin
          checkOutput("pc_at_fetch", pc, cur.addr);
          start_pc_log.push_back(pc);
          start_cyc_log.push_back(cyc);
        end
      end
      cyc++;
    end
  end

  task automatic applyStimulus(input int wt);
    chk_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_re_low", mem_re, 1'b0);
    checkOutput("rst_we_low", mem_we, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_pc", pc, 32'h0);
    wait_cfg = wt;
    for (int i = 0; i < 256; i++) mem_model[i] = mem[i];
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = 32'h0; m_halted = 1'b0; m_halt_pending = 1'b0;
    sched.delete(); start_pc_log.delete(); start_cyc_log.delete();
    instr_lat.delete(); wr_addr_log.delete(); wr_data_log.delete();
    cyc = 0; we_cycles = 0;
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic runToHalt();
    for (int i = 0; i < 400 && !m_halted; i++) @(negedge clk);
    checkOutput("run_reaches_halt", m_halted, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkRegFile();
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("rf[%0d]", i), dut.u_rf.regs[i], m_regs[i]);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  bit found;

  initial begin
    // Program A: ALU ops, taken and untaken beq, jal/jr, then illegal opcode.
    clearMem();
    mem[0]  = 32'h20010005;   // addi $1,$0,5
    mem[1]  = 32'h2002FFFD;   // addi $2,$0,-3
    mem[2]  = 32'h00221820;   // add  $3,$1,$2
    mem[3]  = 32'h0041202A;   // slt  $4,$2,$1
    mem[4]  = 32'h10210002;   // beq  $1,$1,+2  @0x10 -> 0x1C
    mem[5]  = 32'hFC000000;
    mem[7]  = 32'h10220002;   // beq  $1,$2,+2  @0x1C -> 0x20
    mem[8]  = 32'h0C000040;   // jal  0x40      @0x20 -> 0x100
    mem[9]  = 32'hFC000000;   // illegal opcode 0x3F @0x24
    mem[64] = 32'h03E00008;   // jr   $31       @0x100 -> 0x24
    applyStimulus(0);
    runToHalt();
    checkOutput("A_model_r3", m_regs[3], 32'd2);
    checkOutput("A_model_r4", m_regs[4], 32'd1);
    checkOutput("A_model_r31", m_regs[31], 32'h24);
    checkRegFile();
    checkOutput("A_n_instr", start_pc_log.size(), 9);
    if (start_pc_log.size() == 9) begin
      logic [31:0] exp_pc [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                                  32'h1C, 32'h20, 32'h100, 32'h24};
      int exp_lat [9] = '{4, 4, 4, 4, 3, 3, 3, 3, 2};
      for (int i = 0; i < 9; i++) begin
        checkOutput($sformatf("A_pc_seq[%0d]", i), start_pc_log[i], exp_pc[i]);
        checkOutput($sformatf("A_lat[%0d]", i), instr_lat[i], exp_lat[i]);
      end
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("A_dut_cycles[%0d]", i),
                    start_cyc_log[i+1] - start_cyc_log[i], exp_lat[i]);
    end
    checkOutput("A_halted", halted, 1'b1);
    checkOutput("A_final_pc", pc, 32'h28);
`ifdef MULTICYCLE_CORE_PERF_EN
    checkOutput("A_instret", instret_cnt, 32'd8);
    checkOutput("A_cycles", cycle_cnt, 32'd30);
`endif

    // Program B: store then load with three wait cycles on every access.
    clearMem();
    mem[0] = 32'h20010005;    // addi $1,$0,5
    mem[1] = 32'h08000004;    // j    0x10
    mem[4] = 32'hAC010008;    // sw   $1,8($0)
    mem[5] = 32'h8C050008;    // lw   $5,8($0)
    mem[6] = 32'hFC000000;
    applyStimulus(3);
    runToHalt();
    checkOutput("B_we_cycles", we_cycles, 4);
    checkOutput("B_n_writes", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      checkOutput("B_wr_addr", wr_addr_log[0], 32'h8);
      checkOutput("B_wr_data", wr_data_log[0], 32'h5);
    end
    checkOutput("B_model_r5", m_regs[5], 32'd5);
    checkRegFile();
    if (instr_lat.size() >= 4) begin
      checkOutput("B_lat_sw", instr_lat[2], 10);
      checkOutput("B_lat_lw", instr_lat[3], 11);
    end
    if (start_cyc_log.size() >= 5)
      checkOutput("B_dut_lw_cycles", start_cyc_log[4] - start_cyc_log[3], 11);
    else
      checkOutput("B_n_instr", start_cyc_log.size(), 5);

    // Program C: reset while a load is waiting for the memory.
    clearMem();
    mem[0] = 32'h8C06000C;    // lw $6,12($0)
    mem[3] = 32'h00001234;
    applyStimulus(20);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_re && mem_addr == 32'hC) found = 1'b1;
    end
    checkOutput("C_reached_memrd", found, 1'b1);
    chk_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("C_rst_re_low", mem_re, 1'b0);
    checkOutput("C_rst_we_low", mem_we, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("C_state_fetch", 32'(dut.state), 32'(ST_FETCH));
    checkOutput("C_pc_reset", pc, 32'h0);
    checkOutput("C_mdr_clear", dut.mdr, 32'h0);
    checkOutput("C_re_in_reset", mem_re, 1'b0);
`ifdef MULTICYCLE_CORE_PERF_EN
    checkOutput("C_cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("C_instret_cnt", instret_cnt, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("C_fetch_re", mem_re, 1'b1);
    checkOutput("C_fetch_addr", mem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised successor to the team's multicycle MIPS datapath: datapath and control FSM merged into one block.
- Adds a variable-latency memory handshake (req/ready), a configurable data width, a reset PC, and jr support.
- Sits between the top level and a single unified instruction/data memory. Exposes a halt flag and the current PC for the testbench.

Parameters:
- XLEN, 32, datapath/register width; must be >= 32. Instruction is always mem_rdata[31:0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_addr  out  XLEN  byte address (PC on fetch, ALUOut on data access)
- mem_wdata  out  XLEN  store data (B register)
- mem_re  out  1  read request, held until mem_ready
- mem_we  out  1  write request, held until mem_ready
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ready=1
- mem_ready  in  1  access completes at this rising edge
- halted  out  1  sticky; illegal opcode reached
- pc  out  XLEN  current PC

Behaviour:
- Reset (rst=1 at edge):
  - PC<=RESET_PC, state<=FETCH, IR/A/B/MDR/ALUOut<=0, all GPRs<=0, halted<=0.
  - During reset, mem_re=mem_we=0. Reset mid-access abandons the access; the memory must tolerate this.
- $0 reads 0; writes to it are ignored.
- ISA: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), jr (funct 08), lw(23), sw(2B), beq(04), addi(08), j(02), jal(03).
- Any other opcode, or an unknown R-type funct -> HALT.
- Immediate: sign-extended to XLEN. Branch offset: imm<<2.
- Jump target: {PC[XLEN-1:28], IR[25:0], 2'b00}, using the already-incremented PC.
- slt is a signed compare; the result is zero-extended to XLEN. Arithmetic wraps modulo 2^XLEN; no overflow trap.
- States and transitions:
  - FETCH: mem_re=1, mem_addr=PC. On mem_ready: IR<=rdata, PC<=PC+4, ->DECODE. Otherwise stay.
  - DECODE: A<=RF[rs], B<=RF[rt], ALUOut<=PC+(imm<<2). Dispatch on opcode/funct.
  - MEMADR: ALUOut<=A+imm. lw->MEMRD, sw->MEMWR.
  - MEMRD: mem_re=1, mem_addr=ALUOut. On ready: MDR<=rdata, ->MEMWB.
  - MEMWB: RF[rt]<=MDR, ->FETCH.
  - MEMWR: mem_we=1, mem_addr=ALUOut, wdata=B. On ready ->FETCH.
  - EXEC: ALUOut<=A op B. ->RWB, which writes RF[rd] and goes ->FETCH.
  - ADDIEX: ALUOut<=A+imm. ->ADDIWB, which writes RF[rt] and goes ->FETCH.
  - BRANCH: if A==B, PC<=ALUOut. ->FETCH.
  - JUMP: PC<=target. For jal also RF[31]<=PC (i.e. PC+4 of the jal). ->FETCH.
  - JR: PC<=A. ->FETCH.
  - HALT: absorbing; halted=1; no memory requests; only rst exits.
- mem_re and mem_we are never both 1. Request outputs are registered-state decodes (Moore).
- Latency with zero-wait memory (mem_ready tied 1):
  - R-type/addi/sw: 4 cycles; lw: 5; beq/j/jal/jr: 3.
  - Each wait cycle adds 1.
- mem_ready while no request is outstanding is ignored.

Optional Feature:
- Macro: MULTICYCLE_CORE_PERF_EN.
- When defined, adds two outputs:
  - cycle_cnt, 32 bits: increments every non-reset cycle, stops in HALT.
  - instret_cnt, 32 bits: increments on each transition into FETCH from a completing state.
  - Both clear on rst and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode and funct localparams
  - ALU op encoding (ADD, SUB, AND, OR, SLT)
- One natural sub-module: mc_regfile (XLEN-wide, 32 entries, 2 async read ports, 1 sync write port, sync reset, $0 hardwired).
- The ALU and the muxes stay inline.

Test Plan:
- Zero-wait memory. Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1, cycle counts 4/4/4/4.
- sw $1,8($0) then lw $5,8($0), with mem_ready delayed 3 cycles on every access -> mem_we held 4 cycles with addr 8, data 5; $5=5; lw takes 5+6=11 cycles.
- beq $1,$1,+2 at PC 0x10 -> PC=0x1C. Repeat with unequal registers -> PC=0x14.
- jal 0x40 at PC 0x20 -> PC=0x100, $31=0x24. Then jr $31 -> PC=0x24.
- Opcode 0x3F fetched -> halted=1 next cycle. No further mem_re. rst clears halted, PC=RESET_PC.
- rst asserted while in MEMRD waiting -> next cycle state FETCH, PC=RESET_PC, MDR=0, mem_re=0 during reset. With PERF_EN, counters read 0.
